// File: rtl/fb_writer.sv
// fb_writer: framebuffer write stage.
// Wishbone slave in, FWFT FIFO, Wishbone master write bursts out.
// Raster addresses are generated internally by an incrementing register.
// Optional feature macro: FB_WRITER_FRAME_EN enables the frame_done / frame_cnt logic.
module fb_writer #(
  parameter int          HDISP      = 640,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          BURST_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_cyc,
  input  logic                          s_stb,
  input  logic [15:0]                   s_dat,
  output logic                          s_ack,
  output logic                          m_cyc,
  output logic                          m_stb,
  output logic                          m_we,
  output logic [1:0]                    m_sel,
  output logic [31:0]                   m_adr,
  output logic [15:0]                   m_dat,
  input  logic                          m_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic [7:0]                    frame_cnt
);

  localparam int NPIX  = HDISP * VDISP;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CW    = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t           state_q, state_d;
  logic             m_cyc_q, m_cyc_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [31:0]      adr_q, adr_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;

  logic full, empty, push, pop, last_pix;

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign s_ack    = rst & s_cyc & s_stb & ~full;
  assign push     = s_ack;
  // m_cyc_q is high exactly while the FSM sits in BURST
  assign m_stb    = m_cyc_q & ~empty;
  assign pop      = m_stb & m_ack;
  assign last_pix = (pix_q == PIX_W'(NPIX - 1));

  assign m_cyc      = m_cyc_q;
  assign m_we       = m_cyc_q;
  assign m_sel      = {2{m_cyc_q}};
  assign m_adr      = adr_q;
  assign m_dat      = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Raster pixel index and byte address, wrapping at end of frame
  always_comb begin
    pix_d = pix_q;
    adr_d = adr_q;
    if (pop) begin
      if (last_pix) begin
        pix_d = '0;
        adr_d = BASE_ADDR;
      end else begin
        pix_d = pix_q + PIX_W'(1);
        adr_d = adr_q + 32'd2;
      end
    end
  end

  // Master burst FSM next state; IDLE also reacts to a same-cycle push so the
  // first word can be acked one edge after it is written
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (!empty || push) state_d = BURST;
      end
      BURST: begin
        if (pop) begin
          bcnt_d = bcnt_q + CW'(1);
          if (bcnt_d == CW'(BURST_LEN) || level_d == '0) state_d = GAP;
        end
      end
      GAP: begin
        bcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    m_cyc_d = (state_d == BURST);
  end

  // FSM, FIFO control and address registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      m_cyc_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pix_q    <= '0;
      adr_q    <= BASE_ADDR;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      m_cyc_q  <= m_cyc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pix_q    <= pix_d;
      adr_q    <= adr_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // FIFO storage write (push already gated by reset)
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_dat;
  end

`ifdef FB_WRITER_FRAME_EN
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // End-of-frame detection on the ack of the last pixel
  always_comb begin
    frame_done_d = pop & last_pix;
    frame_cnt_d  = frame_cnt_q;
    if (frame_done_d) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  // Frame pulse and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
`else
  assign frame_done = 1'b0;
  assign frame_cnt  = '0;
`endif

endmodule

// File: tb/tb_fb_writer.sv
// Testbench for fb_writer: directed phases plus randomized traffic, checked by
// a scoreboard queue of accepted pixels and a frame-level reference model.
module tb_fb_writer;

  localparam int          HDISP = 4;
  localparam int          VDISP = 2;
  localparam int          NPIX  = HDISP * VDISP;
  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DEPTH = 16;
  localparam int          BL    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_cyc = 1'b0, s_stb = 1'b0;
  logic [15:0] s_dat = '0;
  logic        s_ack;
  logic        m_cyc, m_stb, m_we;
  logic [1:0]  m_sel;
  logic [31:0] m_adr;
  logic [15:0] m_dat;
  logic        m_ack = 1'b0;
  logic [4:0]  fifo_level;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fb_writer #(
    .HDISP(HDISP), .VDISP(VDISP), .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_dat(s_dat), .s_ack(s_ack),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat(m_dat), .m_ack(m_ack),
    .fifo_level(fifo_level), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [15:0] q[$];
  int          bursts[$];
  int          exp_pix = 0;
  int          acks = 0;
  bit          in_gap = 0;
  bit          exp_cyc = 0;
  bit          exp_fd = 0;
  int          exp_fc = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_adr;
  logic [15:0] prev_dat;

  // Monitor: compares DUT against the model every cycle, then advances the
  // model by what happens at the coming clock edge
  always @(negedge clk) begin
    bit push, pop;
    logic [15:0] w;
    chk("m_cyc", m_cyc, exp_cyc);
    chk("fifo_level", fifo_level, q.size());
    chk("s_ack", s_ack, s_cyc && s_stb && rst && (q.size() < DEPTH));
    chk("m_stb", m_stb, m_cyc && (q.size() != 0));
    if (m_cyc) chk("m_we_sel", {m_we, m_sel}, 3'b111);
    else       chk("m_we_sel_idle", {m_we, m_sel}, 3'b000);
`ifdef FB_WRITER_FRAME_EN
    chk("frame_done", frame_done, exp_fd);
    chk("frame_cnt", frame_cnt, exp_fc);
`else
    chk("frame_tied", {frame_done, frame_cnt}, 9'd0);
`endif
    if (prev_stall && m_stb) begin
      chk("stall_adr", m_adr, prev_adr);
      chk("stall_dat", m_dat, prev_dat);
    end
    if (!rst) begin
      q.delete();
      exp_pix = 0; acks = 0; in_gap = 0; exp_cyc = 0;
      exp_fd = 0; exp_fc = 0; prev_stall = 0;
    end else begin
      push = s_ack;
      pop  = m_cyc && m_stb && m_ack;
      if (pop) begin
        if (q.size() == 0) begin
          chk("pop_on_empty", 1, 0);
        end else begin
          w = q.pop_front();
          chk("m_dat", m_dat, w);
          chk("m_adr", m_adr, BASE + 32'(2 * exp_pix));
        end
      end
      if (push) q.push_back(s_dat);
      exp_fd = pop && (exp_pix == NPIX - 1);
      if (exp_fd) exp_fc = (exp_fc + 1) % 256;
      if (pop) exp_pix = (exp_pix + 1) % NPIX;
      if (m_cyc) begin
        if (pop) acks++;
        if (pop && (acks == BL || q.size() == 0)) begin
          bursts.push_back(acks);
          acks = 0; exp_cyc = 0; in_gap = 1;
        end else begin
          exp_cyc = 1;
        end
      end else if (in_gap) begin
        in_gap = 0; exp_cyc = 0;
      end else begin
        exp_cyc = (q.size() != 0);
      end
      prev_stall = m_stb && !m_ack;
      prev_adr   = m_adr;
      prev_dat   = m_dat;
    end
  end

  task automatic drain();
    int n = 0;
    while ((fifo_level != '0 || m_cyc) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 500, 1);
    tick(); tick();
  endtask

  initial begin
    // Reset with upstream strobing
    rst = 1'b0; s_cyc = 1'b1; s_stb = 1'b1; s_dat = 16'h1234;
    repeat (3) tick();
    chk("rst_s_ack", s_ack, 0);
    chk("rst_m_cyc", m_cyc, 0);
    chk("rst_m_adr", m_adr, BASE);
    chk("rst_level", fifo_level, 0);
    s_stb = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Single word with zero-wait ack
    m_ack = 1'b1;
    bursts.delete();
    s_stb = 1'b1; s_dat = 16'hFFFF;
    tick();
    s_stb = 1'b0;
    chk("single_cyc", m_cyc, 1);
    chk("single_dat", m_dat, 16'hFFFF);
    chk("single_adr", m_adr, BASE);
    tick();
    chk("single_gap", m_cyc, 0);
    chk("single_level", fifo_level, 0);
    drain();
    chk("single_bursts", bursts.size(), 1);

    // 20 back-to-back words split into 8, 8, 4
    bursts.delete();
    for (int i = 0; i < 20; i++) begin
      s_stb = 1'b1; s_dat = 16'(16'hA000 + i);
      tick();
    end
    s_stb = 1'b0;
    drain();
    chk("split_nbursts", bursts.size(), 3);
    if (bursts.size() == 3) begin
      chk("split_b0", bursts[0], 8);
      chk("split_b1", bursts[1], 8);
      chk("split_b2", bursts[2], 4);
    end

    // Backpressure: 17 pushes with no ack
    m_ack = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_stb = 1'b1; s_dat = 16'(16'hB000 + i);
      tick();
    end
    chk("bp_level", fifo_level, DEPTH);
    chk("bp_s_ack", s_ack, 0);
    s_stb = 1'b0;
    m_ack = 1'b1;
    drain();

    // Reset mid-burst on the 3rd ack
    m_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_stb = 1'b1; s_dat = 16'(16'hC000 + i);
      tick();
    end
    s_stb = 1'b0;
    tick();
    m_ack = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_cyc", m_cyc, 0);
    chk("mid_rst_level", fifo_level, 0);
    rst = 1'b1;
    s_stb = 1'b1; s_dat = 16'h5A5A;
    tick();
    s_stb = 1'b0;
    begin
      int n = 0;
      while (!(m_cyc && m_stb) && n < 20) begin tick(); n++; end
      chk("post_rst_wait", n < 20, 1);
      chk("post_rst_adr", m_adr, BASE);
    end
    drain();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      s_cyc = ($urandom_range(0, 7) != 0);
      s_stb = ($urandom_range(0, 9) < 7);
      s_dat = 16'($urandom);
      m_ack = ($urandom_range(0, 9) < 6);
      rst   = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst = 1'b1; s_stb = 1'b0; s_cyc = 1'b0; m_ack = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
